// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU    = 1'b0;
  localparam port_id_t PORT_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin SRAM arbiter/sequencer: one access in flight, fixed
// wait cycles, req/ack handshake with a single-cycle Ack pulse per access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] Rdata0,
  output logic [DATA_W-1:0] Rdata1,
  output logic              Busy,
  output logic              Grant_id,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic              SRAM_CE_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_WE_n
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_arbiter: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  state_t                   state;
  port_id_t                 last;
  port_id_t                 pick;
  logic [3:0]               cnt;
  logic                     we_q;
  logic [1:0]               req;
  logic [1:0]               mask;
  logic [1:0]               elig;
  logic [1:0][DATA_W-1:0]   rdata;

  assign req  = {Req1, Req0};
  assign elig = req & ~mask;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick = elig[1] ? PORT_LOADER : PORT_CPU;
    if (&elig) pick = ~last;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      last        <= PORT_LOADER;
      Grant_id    <= PORT_CPU;
      mask        <= '0;
      cnt         <= '0;
      we_q        <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask <= '0;
          if (|elig) begin
            Grant_id    <= pick;
            we_q        <= pick ? We1    : We0;
            SRAM_ADDR   <= pick ? Addr1  : Addr0;
            SRAM_DQ_out <= pick ? Wdata1 : Wdata0;
            cnt         <= 4'(WAIT_CYCLES);
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_q) rdata[Grant_id] <= SRAM_DQ_in;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          last  <= Grant_id;
          // Hide the just-served port for one IDLE cycle so a late Req drop is not re-served.
          mask  <= Grant_id ? 2'b10 : 2'b01;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // WE_n rises on the last ACCESS cycle so data stays driven past the rising edge.
  assign SRAM_CE_n  = (state != ACCESS);
  assign SRAM_OE_n  = !((state == ACCESS) && !we_q);
  assign SRAM_WE_n  = !((state == ACCESS) && we_q && (cnt != 4'd0));
  assign SRAM_DQ_oe = (state == ACCESS) && we_q;

  assign Busy   = (state != IDLE);
  assign Ack0   = (state == DONE) && (Grant_id == PORT_CPU);
  assign Ack1   = (state == DONE) && (Grant_id == PORT_LOADER);
  assign Rdata0 = rdata[0];
  assign Rdata1 = rdata[1];

endmodule
